gas_alarm_controller: RTL

//  Downstream stage of the gas detector sensor. Consumes its 3-bit gas level and drives ventilation and alarm.

---
 rtl/gas_alarm_controller_if.sv | 39 +++
 rtl/gas_alarm_controller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/gas_alarm_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : gas_alarm_controller_if
//  Description : Signal bundle between the gas detector / board and the gas
//                alarm controller. Directions are named from the controller's
//                point of view: *_i are driven into it, *_o come out of it.
//                  level_i      3  debounce-filter input, 0 clean .. 7 max
//                  ack_i        1  operator acknowledge (level-sensitive)
//                  fan_o        1  ventilation enable
//                  buzzer_o     1  audible alarm drive
//                  alarm_led_o  1  high while in ALARM
//                  state_o      2  00 SAFE, 01 WARN, 10 ALARM, 11 COOLDOWN
//                  filt_level_o 3  debounced level
//                  event_cnt_o  8  saturating count of ALARM entries
//  Revision    : 1.0 - initial release
// ============================================================================
interface gas_alarm_controller_if;
   logic [2:0] level_i;
   logic       ack_i;
   logic       fan_o;
   logic       buzzer_o;
   logic       alarm_led_o;
   logic [1:0] state_o;
   logic [2:0] filt_level_o;
   logic [7:0] event_cnt_o;

   // Sensor / board side
   modport master (
      output level_i, ack_i,
      input  fan_o, buzzer_o, alarm_led_o, state_o, filt_level_o, event_cnt_o
   );

   // Controller side
   modport slave (
      input  level_i, ack_i,
      output fan_o, buzzer_o, alarm_led_o, state_o, filt_level_o, event_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/gas_alarm_controller.sv
`default_nettype none
// ============================================================================
//  Module      : gas_alarm_controller
//  Description : Debounces the detector gas level, runs a latching alarm FSM
//                (SAFE / WARN / ALARM / COOLDOWN) with operator ack, mute,
//                fan run-on and a beeping buzzer, and counts alarm entries.
//                  clk   in  system clock, rising edge
//                  arst  in  asynchronous reset, active-low
//                  bus   slave modport of gas_alarm_controller_if
//  Revision    : 1.0 - initial release
// ============================================================================
module gas_alarm_controller #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned WARN_TH       = 3,
   parameter int unsigned ALARM_TH      = 5,
   parameter int unsigned COOL_CYCLES   = 16,
   parameter int unsigned BEEP_CYCLES   = 8
) (
   input  wire logic             clk,
   input  wire logic             arst,
   gas_alarm_controller_if.slave bus
);

   localparam logic [1:0] c_ST_SAFE  = 2'b00;
   localparam logic [1:0] c_ST_WARN  = 2'b01;
   localparam logic [1:0] c_ST_ALARM = 2'b10;
   localparam logic [1:0] c_ST_COOL  = 2'b11;

   localparam logic [3:0] c_STAB_MAX  = 4'(STABLE_CYCLES);
   localparam logic [4:0] c_STAB_RUN  = 5'(STABLE_CYCLES);
   localparam logic [2:0] c_WARN_TH   = 3'(WARN_TH);
   localparam logic [2:0] c_ALARM_TH  = 3'(ALARM_TH);
   localparam logic [7:0] c_COOL_LAST = 8'(COOL_CYCLES - 1);
   localparam logic [7:0] c_BEEP_LAST = 8'(BEEP_CYCLES - 1);

   logic [1:0] state_q,      state_d;
   logic [2:0] last_level_q, last_level_d;
   logic [3:0] stab_cnt_q,   stab_cnt_d;
   logic [2:0] filt_level_q, filt_level_d;
   logic [7:0] cool_cnt_q,   cool_cnt_d;
   logic [7:0] beep_cnt_q,   beep_cnt_d;
   logic       buzz_ph_q,    buzz_ph_d;
   logic       muted_q,      muted_d;
   logic [7:0] event_cnt_q,  event_cnt_d;

   logic       w_same;
   logic [4:0] w_run;
   logic       w_warn;
   logic       w_alarm;
   logic       w_enter_alarm;

   // ---------------------------------------------------------------------
   // Stability filter. w_run is the length of the run of equal samples
   // including the one taken at this edge; stab_cnt_q holds that length
   // minus one, so a run of N is accepted on its N-th edge.
   // ---------------------------------------------------------------------
   always_comb begin
      last_level_d = bus.level_i;
      w_same       = (bus.level_i == last_level_q);
      w_run        = w_same ? ({1'b0, stab_cnt_q} + 5'd2) : 5'd1;
      if (!w_same) begin
         stab_cnt_d = 4'd0;
      end else if (stab_cnt_q >= c_STAB_MAX) begin
         stab_cnt_d = stab_cnt_q;
      end else begin
         stab_cnt_d = stab_cnt_q + 4'd1;
      end
      filt_level_d = (w_run >= c_STAB_RUN) ? bus.level_i : filt_level_q;
   end

   assign w_warn  = (filt_level_q >= c_WARN_TH);
   assign w_alarm = (filt_level_q >= c_ALARM_TH);

   // ---------------------------------------------------------------------
   // State register (FSM state plus its counters and flags)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q      <= c_ST_SAFE;
         last_level_q <= 3'd0;
         stab_cnt_q   <= 4'd0;
         filt_level_q <= 3'd0;
         cool_cnt_q   <= 8'd0;
         beep_cnt_q   <= 8'd0;
         buzz_ph_q    <= 1'b0;
         muted_q      <= 1'b0;
         event_cnt_q  <= 8'd0;
      end else begin
         state_q      <= state_d;
         last_level_q <= last_level_d;
         stab_cnt_q   <= stab_cnt_d;
         filt_level_q <= filt_level_d;
         cool_cnt_q   <= cool_cnt_d;
         beep_cnt_q   <= beep_cnt_d;
         buzz_ph_q    <= buzz_ph_d;
         muted_q      <= muted_d;
         event_cnt_q  <= event_cnt_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_ST_SAFE: begin
            if (w_alarm)     state_d = c_ST_ALARM;
            else if (w_warn) state_d = c_ST_WARN;
         end
         c_ST_WARN: begin
            if (w_alarm)      state_d = c_ST_ALARM;
            else if (!w_warn) state_d = c_ST_COOL;
         end
         c_ST_ALARM: begin
            if (bus.ack_i && !w_alarm) state_d = c_ST_COOL;
         end
         c_ST_COOL: begin
            if (w_alarm)                        state_d = c_ST_ALARM;
            else if (w_warn)                    state_d = c_ST_WARN;
            else if (cool_cnt_q == c_COOL_LAST) state_d = c_ST_SAFE;
         end
         default: state_d = c_ST_SAFE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Counter / flag updates tied to transitions
   // ---------------------------------------------------------------------
   assign w_enter_alarm = (state_d == c_ST_ALARM) && (state_q != c_ST_ALARM);

   always_comb begin
      // cool_cnt only runs while staying in COOLDOWN; every entry or exit
      // starts it from zero.
      cool_cnt_d  = ((state_q == c_ST_COOL) && (state_d == c_ST_COOL))
                    ? cool_cnt_q + 8'd1 : 8'd0;
      beep_cnt_d  = beep_cnt_q;
      buzz_ph_d   = buzz_ph_q;
      muted_d     = muted_q;
      event_cnt_d = event_cnt_q;
      if (w_enter_alarm) begin
         beep_cnt_d  = 8'd0;
         buzz_ph_d   = 1'b1;
         muted_d     = 1'b0;
         event_cnt_d = (event_cnt_q == 8'hFF) ? event_cnt_q : event_cnt_q + 8'd1;
      end else if (state_q == c_ST_ALARM) begin
         if (beep_cnt_q == c_BEEP_LAST) begin
            beep_cnt_d = 8'd0;
            buzz_ph_d  = ~buzz_ph_q;
         end else begin
            beep_cnt_d = beep_cnt_q + 8'd1;
         end
         // Ack while the hazard persists silences the buzzer but keeps ALARM.
         if (bus.ack_i && w_alarm) muted_d = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Moore outputs
   // ---------------------------------------------------------------------
   always_comb begin
      bus.fan_o        = (state_q != c_ST_SAFE);
      bus.alarm_led_o  = (state_q == c_ST_ALARM);
      bus.buzzer_o     = (state_q == c_ST_ALARM) && buzz_ph_q && !muted_q;
      bus.state_o      = state_q;
      bus.filt_level_o = filt_level_q;
      bus.event_cnt_o  = event_cnt_q;
   end

endmodule
`default_nettype wire
